// File: rtl/crc_frame_engine.sv
// crc_frame_engine
// Streaming CRC engine. Framed DATA_W-bit beats arrive over a valid/ready
// handshake, and the engine emits one CRC result per frame. Generate mode
// returns the CRC of the frame. Check mode tests a frame that carries its own
// CRC as trailing beats against RESIDUE.
// Optional feature macro: CRC_STATS_EN adds the frame_cnt/err_cnt statistics
// outputs.

module crc_frame_engine #(
    parameter int               CRC_W   = 8,
    parameter int               DATA_W  = 8,
    parameter logic [CRC_W-1:0] POLY    = 8'h07,
    parameter logic [CRC_W-1:0] INIT    = 8'h00,
    parameter logic [CRC_W-1:0] XOROUT  = 8'h00,
    parameter logic [CRC_W-1:0] RESIDUE = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              crc_valid,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok
`ifdef CRC_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CRC_W-1:0]   crc_reg;
    logic [CRC_W-1:0]   crc_next;
    logic [CRC_W-1:0]   result;
    logic               mode_r;
    logic               frame_mode;
    logic               accept;

    // Shift one whole beat through the CRC register, MSB first. A plain left
    // shift also covers CRC_W == 1, where a [CRC_W-2:0] slice would not exist.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] cur,
                                                  input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = cur;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ data[i];
            r  = (r << 1) ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    // Handshake, the next-register value, and the mode that governs the
    // current frame. On the first beat, that mode is taken straight from the
    // pin.
    always_comb begin
        s_ready    = !rst && (state != DONE);
        crc_valid  = !rst && (state == DONE);
        accept     = s_valid && s_ready;
        crc_next   = crc_step(crc_reg, s_data);
        result     = crc_next ^ XOROUT;
        frame_mode = (state == IDLE) ? mode : mode_r;
    end

    // Next-state logic. The DONE state lasts a single cycle and always
    // returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, RUN: begin
                if (accept) begin
                    state_next = s_last ? DONE : RUN;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sequential logic for the state, the CRC register, and the results that
    // are held between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            crc_reg <= INIT;
            mode_r  <= 1'b0;
            crc_out <= '0;
            crc_ok  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DONE) begin
                crc_reg <= INIT;
            end else if (accept) begin
                crc_reg <= crc_next;
            end
            if (accept && (state == IDLE)) begin
                mode_r <= mode;
            end
            if (accept && s_last) begin
                crc_out <= result;
                crc_ok  <= frame_mode && (result == RESIDUE);
            end
        end
    end

`ifdef CRC_STATS_EN
    // Frame and error counters. Each one advances during the single DONE cycle
    // and wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else if (crc_valid) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (mode_r && !crc_ok) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
